imem_ctrl_51: RTL and testbench
===============================

IMEM_CTRL_51 -- requirements
Module: imem_ctrl_51

Interface
REQ-001 SHALL have parameter MEM_LAST, default 2000, meaning the highest valid byte address of the instruction memory.
REQ-002 SHALL have parameter PC_STRIDE, default 4, meaning the PC increment per fetched word.
REQ-003 clk_51  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_51  in  1  reset; synchronous, active-high.
REQ-005 ld_valid_51 / ld_addr_51 / ld_data_51  in  1/32/32  loader write request: valid, byte address, word.
REQ-006 ld_ready_51  out  1  loader write is accepted this cycle.
REQ-007 start_51 / start_pc_51  in  1/32  begin fetching at start_pc_51.
REQ-008 stop_51  in  1  abort fetching and return to IDLE.
REQ-009 redirect_51 / redirect_pc_51  in  1/32  branch redirect; flush and refetch from redirect_pc_51.
REQ-010 inst_valid_51 / inst_51 / inst_pc_51  out  1/32/32  fetched word and its address, toward decode.
REQ-011 inst_ready_51  in  1  decode accepts the word.
REQ-012 mem_waddr_51 / mem_wdata_51 / mem_write_51  out  32/32/1  memory write port; the write lands on the next rising edge.
REQ-013 mem_raddr_51 / mem_rdata_51  out/in  32/32  memory read port; combinational read.
REQ-014 busy_51 / err_51  out  1/1  FETCH state active / sticky address fault.

Function
REQ-015 SHALL implement states IDLE, FETCH and ERR.
REQ-016 IDLE: ld_ready_51=1; a cycle with ld_valid_51=1 SHALL drive mem_write_51=1, mem_waddr_51=ld_addr_51 and mem_wdata_51=ld_data_51 in that same cycle.
REQ-017 FETCH/ERR: ld_ready_51=0 and mem_write_51=0; loader requests SHALL stall with no write.
REQ-018 IDLE with start_51=1: if start_pc_51[1:0]!=0 or start_pc_51>MEM_LAST, go to ERR; otherwise set pc=start_pc_51 and go to FETCH.
REQ-019 IDLE with start_51 and ld_valid_51 in the same cycle: perform the write and also take the start.
REQ-020 FETCH: mem_raddr_51=pc every cycle.
REQ-021 FETCH, output register empty or being consumed (inst_ready_51=1): capture inst_51=mem_rdata_51 and inst_pc_51=pc, set inst_valid_51=1, pc+=PC_STRIDE.
REQ-022 Read-to-valid latency SHALL be 1 cycle; at most one word is outstanding.
REQ-023 With inst_ready_51=1 the block SHALL sustain 1 word/cycle.
REQ-024 Valid/ready rule: inst_valid_51 and inst_51 SHALL hold stable while inst_valid_51=1 and inst_ready_51=0.
REQ-025 A handshake SHALL occur on each cycle with inst_valid_51 & inst_ready_51.
REQ-026 Redirect in FETCH: the next cycle inst_valid_51=0 and pc=redirect_pc_51; a handshake in the same cycle still completes.
REQ-027 Redirect in IDLE or ERR SHALL be ignored.
REQ-028 Redirect to a misaligned target or a target above MEM_LAST SHALL go to ERR.
REQ-029 Before a capture that would read pc>MEM_LAST, the block SHALL go to ERR with no capture.
REQ-030 Entering ERR SHALL set err_51=1 and inst_valid_51=0.
REQ-031 stop_51 in FETCH or ERR: next state IDLE, inst_valid_51=0, err_51 cleared.
REQ-032 Priority SHALL be: stop_51, then redirect_51, then sequential fetch.
REQ-033 PC arithmetic SHALL be 32-bit unsigned; wrap-around is unreachable because of REQ-029.
REQ-034 busy_51=1 exactly in FETCH.

Reset
REQ-035 While rst_51=1 at a rising edge, the next state SHALL be: IDLE, pc=0, inst_valid_51=0, inst_51=0, inst_pc_51=0, err_51=0.
REQ-036 Combinational outputs after that edge SHALL be: ld_ready_51=1, busy_51=0, mem_write_51=0, mem_raddr_51=0.
REQ-037 Reset in the middle of a fetch SHALL discard the held word; no handshake occurs on the reset cycle.
REQ-038 Reset SHALL take priority over every other input.

Structure
REQ-039 Package imem_ctrl_pkg_51 SHALL hold the state enum, PC_STRIDE and MEM_LAST defaults.
REQ-040 Sub-module imem_out_reg_51 SHALL implement the one-entry valid/ready output register with flush.

Verification
REQ-041 Load: in IDLE, write 0x00800684@8 and 0x0000003F@12, start_pc=8, ready=1 -> inst_pc 8 then 12 on consecutive cycles, with matching data.
REQ-042 Backpressure: inst_ready=0 for 3 cycles -> inst_51 and inst_pc_51 held; pc does not advance; resumes at 1 word/cycle.
REQ-043 Redirect: redirect_pc=28 while inst_pc=60 -> next cycle inst_valid=0; following cycle inst_pc=28.
REQ-044 Bounds: start_pc=1996 -> words at 1996 and 2000 delivered, then err_51=1; start_pc=6 -> ERR immediately.
REQ-045 Loader stall: ld_valid=1 during FETCH -> ld_ready=0 and mem_write=0; after stop_51 the write lands on the first IDLE cycle.
REQ-046 Reset mid-fetch: rst_51 pulsed while inst_valid=1 -> next cycle inst_valid=0, state IDLE, pc=0, err_51=0.

Source files
------------

// File: rtl/imem_ctrl_pkg_51.sv
// imem_ctrl_pkg_51: shared state encoding, default geometry and address-fault helper for the fetch controller
package imem_ctrl_pkg_51;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ERR   = 2'd2
    } state_e;
    localparam int MEM_LAST_DEF  = 2000;
    localparam int PC_STRIDE_DEF = 4;
    function automatic logic pc_bad(input logic [31:0] pc, input logic [31:0] last);
        return (pc[1:0] != 2'b00) || (pc > last);
    endfunction
endpackage

// File: rtl/imem_out_reg_51.sv
// imem_out_reg_51: one-entry valid/ready output register with flush
module imem_out_reg_51
    import imem_ctrl_pkg_51::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic        ready,
    input  logic [31:0] in_data,
    input  logic [31:0] in_pc,
    output logic        valid,
    output logic [31:0] data,
    output logic [31:0] pc
);
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d, pc_q, pc_d;
    always_comb begin
        valid_d = flush ? 1'b0 : load ? 1'b1 : valid_q & ~ready;
        data_d  = load ? in_data : data_q;
        pc_d    = load ? in_pc : pc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end
    assign valid = valid_q;
    assign data  = data_q;
    assign pc    = pc_q;
endmodule

// File: rtl/imem_ctrl_51.sv
// imem_ctrl_51: instruction memory loader/fetch controller with valid/ready delivery toward decode
module imem_ctrl_51
    import imem_ctrl_pkg_51::*;
#(
    parameter int MEM_LAST  = MEM_LAST_DEF,
    parameter int PC_STRIDE = PC_STRIDE_DEF
) (
    input  logic        clk_51,
    input  logic        rst_51,
    input  logic        ld_valid_51,
    input  logic [31:0] ld_addr_51,
    input  logic [31:0] ld_data_51,
    output logic        ld_ready_51,
    input  logic        start_51,
    input  logic [31:0] start_pc_51,
    input  logic        stop_51,
    input  logic        redirect_51,
    input  logic [31:0] redirect_pc_51,
    output logic        inst_valid_51,
    output logic [31:0] inst_51,
    output logic [31:0] inst_pc_51,
    input  logic        inst_ready_51,
    output logic [31:0] mem_waddr_51,
    output logic [31:0] mem_wdata_51,
    output logic        mem_write_51,
    output logic [31:0] mem_raddr_51,
    input  logic [31:0] mem_rdata_51,
    output logic        busy_51,
    output logic        err_51
);
    localparam logic [31:0] LAST   = 32'(MEM_LAST);
    localparam logic [31:0] STRIDE = 32'(PC_STRIDE);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic        flush, load, free;
    assign free = ~inst_valid_51 | inst_ready_51;
    // stop outranks redirect, which outranks the sequential fetch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        flush   = 1'b0;
        load    = 1'b0;
        if (stop_51 && state_q != S_IDLE) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
            flush   = 1'b1;
        end else if (state_q == S_IDLE && start_51) begin
            state_d = pc_bad(start_pc_51, LAST) ? S_ERR : S_FETCH;
            err_d   = pc_bad(start_pc_51, LAST);
            pc_d    = pc_bad(start_pc_51, LAST) ? pc_q : start_pc_51;
        end else if (state_q == S_FETCH && redirect_51) begin
            flush   = 1'b1;
            state_d = pc_bad(redirect_pc_51, LAST) ? S_ERR : S_FETCH;
            err_d   = pc_bad(redirect_pc_51, LAST);
            pc_d    = pc_bad(redirect_pc_51, LAST) ? pc_q : redirect_pc_51;
        end else if (state_q == S_FETCH && free) begin
            if (pc_q > LAST) begin
                state_d = S_ERR;
                err_d   = 1'b1;
                flush   = 1'b1;
            end else begin
                load = 1'b1;
                pc_d = pc_q + STRIDE;
            end
        end
    end
    always_ff @(posedge clk_51) begin
        if (rst_51) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end
    imem_out_reg_51 u_out (
        .clk     (clk_51),
        .rst     (rst_51),
        .flush   (flush),
        .load    (load),
        .ready   (inst_ready_51),
        .in_data (mem_rdata_51),
        .in_pc   (pc_q),
        .valid   (inst_valid_51),
        .data    (inst_51),
        .pc      (inst_pc_51)
    );
    assign ld_ready_51  = (state_q == S_IDLE);
    assign mem_write_51 = ld_ready_51 & ld_valid_51;
    assign mem_waddr_51 = ld_addr_51;
    assign mem_wdata_51 = ld_data_51;
    assign busy_51      = (state_q == S_FETCH);
    assign mem_raddr_51 = busy_51 ? pc_q : 32'd0;
    assign err_51       = err_q;
endmodule

// File: tb/tb_imem_ctrl_51.sv
// tb_imem_ctrl_51: scenario tasks plus a randomized stream checked against an expected-PC model
module tb_imem_ctrl_51;
    logic        clk_51 = 1'b0;
    logic        rst_51, ld_valid_51, start_51, stop_51, redirect_51, inst_ready_51;
    logic [31:0] ld_addr_51, ld_data_51, start_pc_51, redirect_pc_51, mem_rdata_51;
    logic        ld_ready_51, inst_valid_51, mem_write_51, busy_51, err_51;
    logic [31:0] inst_51, inst_pc_51, mem_waddr_51, mem_wdata_51, mem_raddr_51;
    logic [31:0] mem [0:1023];
    int checks = 0;
    int failures = 0;

    imem_ctrl_51 dut (
        .clk_51(clk_51), .rst_51(rst_51),
        .ld_valid_51(ld_valid_51), .ld_addr_51(ld_addr_51), .ld_data_51(ld_data_51), .ld_ready_51(ld_ready_51),
        .start_51(start_51), .start_pc_51(start_pc_51), .stop_51(stop_51),
        .redirect_51(redirect_51), .redirect_pc_51(redirect_pc_51),
        .inst_valid_51(inst_valid_51), .inst_51(inst_51), .inst_pc_51(inst_pc_51), .inst_ready_51(inst_ready_51),
        .mem_waddr_51(mem_waddr_51), .mem_wdata_51(mem_wdata_51), .mem_write_51(mem_write_51),
        .mem_raddr_51(mem_raddr_51), .mem_rdata_51(mem_rdata_51),
        .busy_51(busy_51), .err_51(err_51)
    );

    always #5 clk_51 = ~clk_51;

    always @(posedge clk_51) begin
        if (rst_51) begin
            for (int i = 0; i < 1024; i++) mem[i] <= $urandom;
        end else if (mem_write_51) begin
            mem[mem_waddr_51[11:2]] <= mem_wdata_51;
        end
    end
    assign mem_rdata_51 = mem[mem_raddr_51[11:2]];

    task automatic tick;
        @(posedge clk_51);
        #1;
    endtask

    task automatic idle_inputs;
        ld_valid_51 = 0; ld_addr_51 = 0; ld_data_51 = 0; start_51 = 0; start_pc_51 = 0;
        stop_51 = 0; redirect_51 = 0; redirect_pc_51 = 0; inst_ready_51 = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_51 = 1;
        tick();
        tick();
        rst_51 = 0;
        @(negedge clk_51);
        checks++; if (inst_valid_51 !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h want=0", inst_valid_51); end
        checks++; if (inst_51 !== 32'd0) begin failures++; $display("FAIL rst_inst got=%0h want=0", inst_51); end
        checks++; if (inst_pc_51 !== 32'd0) begin failures++; $display("FAIL rst_inst_pc got=%0h want=0", inst_pc_51); end
        checks++; if (err_51 !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h want=0", err_51); end
        checks++; if (ld_ready_51 !== 1'b1) begin failures++; $display("FAIL rst_ld_ready got=%0h want=1", ld_ready_51); end
        checks++; if (busy_51 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h want=0", busy_51); end
        checks++; if (mem_write_51 !== 1'b0) begin failures++; $display("FAIL rst_mem_write got=%0h want=0", mem_write_51); end
        checks++; if (mem_raddr_51 !== 32'd0) begin failures++; $display("FAIL rst_raddr got=%0h want=0", mem_raddr_51); end
    endtask

    task automatic test_load;
        tick();
        ld_valid_51 = 1; ld_addr_51 = 8; ld_data_51 = 32'h0080_0684;
        @(negedge clk_51);
        checks++; if (ld_ready_51 !== 1'b1) begin failures++; $display("FAIL load_ready got=%0h want=1", ld_ready_51); end
        checks++; if (mem_write_51 !== 1'b1) begin failures++; $display("FAIL load_write got=%0h want=1", mem_write_51); end
        checks++; if (mem_waddr_51 !== 32'd8) begin failures++; $display("FAIL load_waddr got=%0h want=8", mem_waddr_51); end
        checks++; if (mem_wdata_51 !== 32'h0080_0684) begin failures++; $display("FAIL load_wdata got=%0h want=800684", mem_wdata_51); end
        tick();
        ld_addr_51 = 12; ld_data_51 = 32'h0000_003F; start_51 = 1; start_pc_51 = 8; inst_ready_51 = 1;
        @(negedge clk_51);
        checks++; if (mem_write_51 !== 1'b1) begin failures++; $display("FAIL load_start_write got=%0h want=1", mem_write_51); end
        tick();
        ld_valid_51 = 0; start_51 = 0;
        @(negedge clk_51);
        checks++; if (busy_51 !== 1'b1) begin failures++; $display("FAIL load_busy got=%0h want=1", busy_51); end
        checks++; if (inst_valid_51 !== 1'b0) begin failures++; $display("FAIL load_first_valid got=%0h want=0", inst_valid_51); end
        checks++; if (mem_raddr_51 !== 32'd8) begin failures++; $display("FAIL load_raddr got=%0h want=8", mem_raddr_51); end
        tick();
        @(negedge clk_51);
        checks++; if (inst_valid_51 !== 1'b1 || inst_pc_51 !== 32'd8) begin failures++; $display("FAIL load_w0_pc got=%0h/%0h want=1/8", inst_valid_51, inst_pc_51); end
        checks++; if (inst_51 !== 32'h0080_0684) begin failures++; $display("FAIL load_w0_data got=%0h want=800684", inst_51); end
        tick();
        @(negedge clk_51);
        checks++; if (inst_valid_51 !== 1'b1 || inst_pc_51 !== 32'd12) begin failures++; $display("FAIL load_w1_pc got=%0h/%0h want=1/c", inst_valid_51, inst_pc_51); end
        checks++; if (inst_51 !== 32'h0000_003F) begin failures++; $display("FAIL load_w1_data got=%0h want=3f", inst_51); end
        stop_51 = 1;
        tick();
        stop_51 = 0;
        @(negedge clk_51);
        checks++; if (busy_51 !== 1'b0 || inst_valid_51 !== 1'b0) begin failures++; $display("FAIL load_stop got=%0h/%0h want=0/0", busy_51, inst_valid_51); end
    endtask

    task automatic test_backpressure;
        logic [31:0] w100;
        tick();
        start_51 = 1; start_pc_51 = 100; inst_ready_51 = 1;
        tick();
        start_51 = 0;
        @(negedge clk_51);
        checks++; if (inst_valid_51 !== 1'b0) begin failures++; $display("FAIL bp_first_valid got=%0h want=0", inst_valid_51); end
        tick();
        inst_ready_51 = 0;
        w100 = mem[25];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_51);
            checks++; if (inst_valid_51 !== 1'b1 || inst_pc_51 !== 32'd100 || inst_51 !== w100) begin
                failures++; $display("FAIL bp_hold%0d got=%0h/%0h/%0h want=1/64/%0h", c, inst_valid_51, inst_pc_51, inst_51, w100);
            end
            checks++; if (mem_raddr_51 !== 32'd104) begin failures++; $display("FAIL bp_pc_hold%0d got=%0h want=68", c, mem_raddr_51); end
            if (c < 2) tick();
        end
        tick();
        inst_ready_51 = 1;
        @(negedge clk_51);
        checks++; if (inst_pc_51 !== 32'd100) begin failures++; $display("FAIL bp_release got=%0h want=64", inst_pc_51); end
        for (int k = 1; k <= 2; k++) begin
            tick();
            @(negedge clk_51);
            checks++; if (inst_valid_51 !== 1'b1 || inst_pc_51 !== 32'(100 + 4 * k) || inst_51 !== mem[25 + k]) begin
                failures++; $display("FAIL bp_resume%0d got=%0h/%0h want=%0h/%0h", k, inst_pc_51, inst_51, 100 + 4 * k, mem[25 + k]);
            end
        end
        stop_51 = 1;
        tick();
        stop_51 = 0;
    endtask

    task automatic test_redirect;
        logic found = 0;
        tick();
        start_51 = 1; start_pc_51 = 40; inst_ready_51 = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            start_51 = 0;
            @(negedge clk_51);
            found = inst_valid_51 && inst_pc_51 == 32'd60;
        end
        checks++; if (!found) begin failures++; $display("FAIL redir_reach60 got=%0h want=3c", inst_pc_51); end
        redirect_51 = 1; redirect_pc_51 = 28;
        tick();
        redirect_51 = 0;
        @(negedge clk_51);
        checks++; if (inst_valid_51 !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0h want=0", inst_valid_51); end
        checks++; if (mem_raddr_51 !== 32'd28) begin failures++; $display("FAIL redir_raddr got=%0h want=1c", mem_raddr_51); end
        tick();
        @(negedge clk_51);
        checks++; if (inst_valid_51 !== 1'b1 || inst_pc_51 !== 32'd28 || inst_51 !== mem[7]) begin
            failures++; $display("FAIL redir_target got=%0h/%0h want=1c/%0h", inst_pc_51, inst_51, mem[7]);
        end
        redirect_51 = 1; redirect_pc_51 = 30;
        tick();
        redirect_51 = 0;
        @(negedge clk_51);
        checks++; if (err_51 !== 1'b1 || busy_51 !== 1'b0 || inst_valid_51 !== 1'b0) begin
            failures++; $display("FAIL redir_misaligned got=%0h/%0h/%0h want=1/0/0", err_51, busy_51, inst_valid_51);
        end
        redirect_51 = 1; redirect_pc_51 = 0;
        tick();
        redirect_51 = 0;
        @(negedge clk_51);
        checks++; if (err_51 !== 1'b1 || busy_51 !== 1'b0) begin failures++; $display("FAIL redir_in_err got=%0h/%0h want=1/0", err_51, busy_51); end
        stop_51 = 1;
        tick();
        stop_51 = 0;
        @(negedge clk_51);
        checks++; if (err_51 !== 1'b0 || ld_ready_51 !== 1'b1) begin failures++; $display("FAIL redir_stop_clear got=%0h/%0h want=0/1", err_51, ld_ready_51); end
    endtask

    task automatic test_bounds;
        tick();
        start_51 = 1; start_pc_51 = 1996; inst_ready_51 = 1;
        tick();
        start_51 = 0;
        tick();
        @(negedge clk_51);
        checks++; if (inst_valid_51 !== 1'b1 || inst_pc_51 !== 32'd1996 || inst_51 !== mem[499]) begin
            failures++; $display("FAIL bound_1996 got=%0h/%0h/%0h want=1/7cc/%0h", inst_valid_51, inst_pc_51, inst_51, mem[499]);
        end
        tick();
        @(negedge clk_51);
        checks++; if (inst_valid_51 !== 1'b1 || inst_pc_51 !== 32'd2000 || inst_51 !== mem[500]) begin
            failures++; $display("FAIL bound_2000 got=%0h/%0h/%0h want=1/7d0/%0h", inst_valid_51, inst_pc_51, inst_51, mem[500]);
        end
        tick();
        @(negedge clk_51);
        checks++; if (err_51 !== 1'b1 || inst_valid_51 !== 1'b0 || busy_51 !== 1'b0) begin
            failures++; $display("FAIL bound_err got=%0h/%0h/%0h want=1/0/0", err_51, inst_valid_51, busy_51);
        end
        stop_51 = 1;
        tick();
        stop_51 = 0; start_51 = 1; start_pc_51 = 6;
        tick();
        start_51 = 0;
        @(negedge clk_51);
        checks++; if (err_51 !== 1'b1 || busy_51 !== 1'b0) begin failures++; $display("FAIL bound_start6 got=%0h/%0h want=1/0", err_51, busy_51); end
        stop_51 = 1;
        tick();
        stop_51 = 0;
    endtask

    task automatic test_loader_stall;
        logic [31:0] d;
        d = $urandom;
        tick();
        start_51 = 1; start_pc_51 = 0; inst_ready_51 = 1;
        tick();
        start_51 = 0; ld_valid_51 = 1; ld_addr_51 = 40; ld_data_51 = d;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_51);
            checks++; if (ld_ready_51 !== 1'b0 || mem_write_51 !== 1'b0) begin
                failures++; $display("FAIL stall%0d got=%0h/%0h want=0/0", c, ld_ready_51, mem_write_51);
            end
            if (c == 0) tick();
        end
        stop_51 = 1;
        tick();
        stop_51 = 0;
        @(negedge clk_51);
        checks++; if (ld_ready_51 !== 1'b1 || mem_write_51 !== 1'b1 || mem_waddr_51 !== 32'd40 || mem_wdata_51 !== d) begin
            failures++; $display("FAIL stall_land got=%0h/%0h/%0h/%0h want=1/1/28/%0h", ld_ready_51, mem_write_51, mem_waddr_51, mem_wdata_51, d);
        end
        tick();
        ld_valid_51 = 0;
        @(negedge clk_51);
        checks++; if (mem[10] !== d) begin failures++; $display("FAIL stall_mem got=%0h want=%0h", mem[10], d); end
    endtask

    task automatic test_reset_mid;
        tick();
        start_51 = 1; start_pc_51 = 200; inst_ready_51 = 0;
        tick();
        start_51 = 0;
        tick();
        @(negedge clk_51);
        checks++; if (inst_valid_51 !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0h want=1", inst_valid_51); end
        rst_51 = 1; inst_ready_51 = 1;
        tick();
        rst_51 = 0; inst_ready_51 = 0;
        @(negedge clk_51);
        checks++; if (inst_valid_51 !== 1'b0 || busy_51 !== 1'b0 || err_51 !== 1'b0) begin
            failures++; $display("FAIL rmid_state got=%0h/%0h/%0h want=0/0/0", inst_valid_51, busy_51, err_51);
        end
        checks++; if (mem_raddr_51 !== 32'd0 || inst_pc_51 !== 32'd0 || inst_51 !== 32'd0 || ld_ready_51 !== 1'b1) begin
            failures++; $display("FAIL rmid_regs got=%0h/%0h/%0h/%0h want=0/0/0/1", mem_raddr_51, inst_pc_51, inst_51, ld_ready_51);
        end
    endtask

    task automatic test_random_stream;
        logic [31:0] exp_pc, prev_inst, prev_pc;
        logic prev_valid = 0, prev_ready = 0, prev_redir = 0;
        int delivered = 0;
        tick();
        start_51 = 1; start_pc_51 = 32'($urandom_range(0, 100)) * 4; inst_ready_51 = 1;
        exp_pc = start_pc_51;
        prev_inst = 0; prev_pc = 0;
        tick();
        start_51 = 0;
        for (int c = 0; c < 150; c++) begin
            inst_ready_51 = $urandom_range(0, 3) != 0;
            redirect_51 = $urandom_range(0, 15) == 0;
            redirect_pc_51 = 32'($urandom_range(0, 250)) * 4;
            @(negedge clk_51);
            if (prev_redir) begin
                checks++; if (inst_valid_51 !== 1'b0) begin failures++; $display("FAIL rnd_flush c=%0d got=%0h want=0", c, inst_valid_51); end
            end else if (inst_valid_51 && prev_valid && !prev_ready) begin
                checks++; if (inst_51 !== prev_inst || inst_pc_51 !== prev_pc) begin
                    failures++; $display("FAIL rnd_hold c=%0d got=%0h/%0h want=%0h/%0h", c, inst_pc_51, inst_51, prev_pc, prev_inst);
                end
            end else if (inst_valid_51) begin
                checks++; if (inst_pc_51 !== exp_pc || inst_51 !== mem[exp_pc[11:2]]) begin
                    failures++; $display("FAIL rnd_word c=%0d got=%0h/%0h want=%0h/%0h", c, inst_pc_51, inst_51, exp_pc, mem[exp_pc[11:2]]);
                end
                exp_pc = exp_pc + 4;
                delivered++;
            end
            if (redirect_51) exp_pc = redirect_pc_51;
            prev_valid = inst_valid_51; prev_ready = inst_ready_51; prev_redir = redirect_51;
            prev_inst = inst_51; prev_pc = inst_pc_51;
            tick();
        end
        redirect_51 = 0;
        checks++; if (delivered < 20) begin failures++; $display("FAIL rnd_throughput got=%0d want>=20", delivered); end
        stop_51 = 1;
        tick();
        stop_51 = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load();
        test_backpressure();
        test_redirect();
        test_bounds();
        test_loader_stall();
        test_reset_mid();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
